// File: rtl/alu_issue_pkg.sv
// Shared ALU op codes and RV32I major opcodes for the execute-stage issue block.
package alu_issue_pkg;

  typedef enum logic [4:0] {
    AluAdd  = 5'd0,
    AluSub  = 5'd1,
    AluAnd  = 5'd2,
    AluOr   = 5'd3,
    AluXor  = 5'd4,
    AluPas  = 5'd5,
    AluLt   = 5'd6,
    AluLtu  = 5'd7,
    AluGe   = 5'd8,
    AluGeu  = 5'd9,
    AluEq   = 5'd10,
    AluNe   = 5'd11
  } alu_op_e;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

endpackage

// File: rtl/alu_issue_if.sv
// Issue handshake bundle: upstream instruction channel and downstream ALU-input channel.
interface alu_issue_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [4:0]      alu_op;
  logic [4:0]      rd;
  logic            is_branch;
  logic            illegal;

  // Environment side: feeds instructions and consumes ALU inputs.
  modport master (
    output in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_op, rd, is_branch, illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_op, rd, is_branch, illegal
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode to ALU op code and operand selection.
module alu_op_decode
  import alu_issue_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output alu_op_e         alu_op,
  output logic [4:0]      rd,
  output logic            is_branch,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign rd     = instr[11:7];

  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));

  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = AluAdd;
    is_branch = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OpcOpImm: begin
        alu_a = rs1;
        alu_b = imm_i;
        case (f3)
          3'b000:  alu_op = AluAdd;
          3'b100:  alu_op = AluXor;
          3'b110:  alu_op = AluOr;
          3'b111:  alu_op = AluAnd;
          3'b010:  alu_op = AluLt;
          3'b011:  alu_op = AluLtu;
          default: illegal = 1'b1;
        endcase
      end
      OpcOp: begin
        alu_a = rs1;
        alu_b = rs2;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  alu_op = AluAdd;
            3'b100:  alu_op = AluXor;
            3'b110:  alu_op = AluOr;
            3'b111:  alu_op = AluAnd;
            3'b010:  alu_op = AluLt;
            3'b011:  alu_op = AluLtu;
            default: illegal = 1'b1;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          alu_op = AluSub;
        end else begin
          illegal = 1'b1;
        end
      end
      OpcLui: begin
        alu_op = AluPas;
        alu_b  = imm_u;
      end
      OpcAuipc: begin
        alu_a = pc;
        alu_b = imm_u;
      end
      OpcBranch: begin
        alu_a     = rs1;
        alu_b     = rs2;
        is_branch = 1'b1;
        case (f3)
          3'b000:  alu_op = AluEq;
          3'b001:  alu_op = AluNe;
          3'b100:  alu_op = AluLt;
          3'b101:  alu_op = AluGe;
          3'b110:  alu_op = AluLtu;
          3'b111:  alu_op = AluGeu;
          default: illegal = 1'b1;
        endcase
      end
      OpcLoad: begin
        alu_a = rs1;
        alu_b = imm_i;
      end
      OpcStore: begin
        alu_a = rs1;
        alu_b = imm_s;
      end
      OpcJal, OpcJalr: begin
        // ALU produces the link value pc+4.
        alu_a = pc;
        alu_b = XLEN'(4);
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      alu_a     = '0;
      alu_b     = '0;
      alu_op    = AluAdd;
      is_branch = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Execute-stage issue: decodes at the input, then a registered output stage backed by one
// skid entry so in_ready can come straight from a flop.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  alu_issue_if.slave  bus
);

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    alu_op_e         op;
    logic [4:0]      rd;
    logic            is_branch;
    logic            illegal;
  } dec_t;

  localparam dec_t DecReset = '{
    a: '0, b: '0, op: AluAdd, rd: '0, is_branch: 1'b0, illegal: 1'b0
  };

  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  alu_op_e         dec_op;
  logic [4:0]      dec_rd;
  logic            dec_is_branch;
  logic            dec_illegal;
  dec_t            dec;

  dec_t out_q, out_d;
  dec_t skid_q, skid_d;
  logic out_valid_q, out_valid_d;
  logic skid_valid_q, skid_valid_d;
  logic in_ready_q, in_ready_d;
  logic accept;
  logic out_load;

  alu_op_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr     (bus.in_instr),
    .pc        (bus.in_pc),
    .rs1       (bus.in_rs1),
    .rs2       (bus.in_rs2),
    .alu_a     (dec_a),
    .alu_b     (dec_b),
    .alu_op    (dec_op),
    .rd        (dec_rd),
    .is_branch (dec_is_branch),
    .illegal   (dec_illegal)
  );

  assign dec = '{
    a: dec_a, b: dec_b, op: dec_op, rd: dec_rd, is_branch: dec_is_branch, illegal: dec_illegal
  };

  assign accept   = bus.in_valid & in_ready_q;
  assign out_load = ~out_valid_q | bus.out_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_load) begin
      // in_ready is low whenever the skid is full, so accept and skid_valid_q never coincide.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= DecReset;
      skid_q       <= DecReset;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_a     = out_q.a;
  assign bus.alu_b     = out_q.b;
  assign bus.alu_op    = out_q.op;
  assign bus.rd        = out_q.rd;
  assign bus.is_branch = out_q.is_branch;
  assign bus.illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vectors, back-pressure ordering, flush and async reset.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  int   total = 0;
  int   bad = 0;

  alu_issue_if #(.XLEN(32)) bus ();

  alu_issue #(
    .XLEN (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
  endtask

  // Reference ALU for the ops exercised end to end.
  function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      5'(AluSub): return a - b;
      5'(AluGeu): return {31'b0, a >= b};
      default:    return a + b;
    endcase
  endfunction

  logic [31:0] bp_tab [4];
  bit          exp_ir [7];
  int          idx;
  int          nout;

  initial begin
    bp_tab = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
    exp_ir = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.out_ready = 1'b1;

    #2 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'(AluAdd));
    chk("rst_rd", 32'(bus.rd), 32'd0);
    chk("rst_is_branch", 32'(bus.is_branch), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    tick();
    rst_n = 1'b1;

    // ADDI x1,x0,-5
    drive(32'hFFB00093, 32'h0, 32'd0, 32'd0);
    tick();
    chk("addi_valid", 32'(bus.out_valid), 32'd1);
    chk("addi_op", 32'(bus.alu_op), 32'(AluAdd));
    chk("addi_a", bus.alu_a, 32'd0);
    chk("addi_b", bus.alu_b, 32'hFFFFFFFB);
    chk("addi_rd", 32'(bus.rd), 32'd1);
    chk("addi_illegal", 32'(bus.illegal), 32'd0);

    // SUB x0,x1,x2
    drive(32'h40208033, 32'h4, 32'd10, 32'd3);
    tick();
    chk("sub_op", 32'(bus.alu_op), 32'(AluSub));
    chk("sub_a", bus.alu_a, 32'd10);
    chk("sub_b", bus.alu_b, 32'd3);
    chk("sub_result", alu_model(bus.alu_op, bus.alu_a, bus.alu_b), 32'd7);

    // BGEU x1,x2
    drive(32'h0020F063, 32'h8, 32'd10, 32'd3);
    tick();
    chk("bgeu_op", 32'(bus.alu_op), 32'(AluGeu));
    chk("bgeu_is_branch", 32'(bus.is_branch), 32'd1);
    chk("bgeu_result", alu_model(bus.alu_op, bus.alu_a, bus.alu_b), 32'd1);

    // AUIPC x5,0x12345
    drive(32'h12345297, 32'h100, 32'hDEAD, 32'hBEEF);
    tick();
    chk("auipc_op", 32'(bus.alu_op), 32'(AluAdd));
    chk("auipc_a", bus.alu_a, 32'h100);
    chk("auipc_b", bus.alu_b, 32'h12345000);
    chk("auipc_rd", 32'(bus.rd), 32'd5);
    chk("auipc_is_branch", 32'(bus.is_branch), 32'd0);

    // LUI x6,0x12345
    drive(32'h12345337, 32'h104, 32'hDEAD, 32'hBEEF);
    tick();
    chk("lui_op", 32'(bus.alu_op), 32'(AluPas));
    chk("lui_a", bus.alu_a, 32'd0);
    chk("lui_b", bus.alu_b, 32'h12345000);

    // SW x2,-4(x1): split S immediate, rd field passes through
    drive(32'hFE20AE23, 32'h108, 32'h1000, 32'h77);
    tick();
    chk("sw_op", 32'(bus.alu_op), 32'(AluAdd));
    chk("sw_a", bus.alu_a, 32'h1000);
    chk("sw_b", bus.alu_b, 32'hFFFFFFFC);
    chk("sw_rd", 32'(bus.rd), 32'd28);

    // JAL x1,4: link value
    drive(32'h004000EF, 32'h200, 32'h55, 32'h66);
    tick();
    chk("jal_a", bus.alu_a, 32'h200);
    chk("jal_b", bus.alu_b, 32'd4);
    chk("jal_rd", 32'(bus.rd), 32'd1);

    // SLLI and unknown opcode are illegal but still transfer
    drive(32'h00209093, 32'h300, 32'h55, 32'h66);
    tick();
    chk("slli_valid", 32'(bus.out_valid), 32'd1);
    chk("slli_illegal", 32'(bus.illegal), 32'd1);
    chk("slli_op", 32'(bus.alu_op), 32'(AluAdd));
    chk("slli_a", bus.alu_a, 32'd0);
    chk("slli_b", bus.alu_b, 32'd0);
    drive(32'h0000007F, 32'h304, 32'h55, 32'h66);
    tick();
    chk("opc7f_illegal", 32'(bus.illegal), 32'd1);
    chk("opc7f_a", bus.alu_a, 32'd0);
    chk("opc7f_b", bus.alu_b, 32'd0);
    chk("opc7f_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(bus.out_valid), 32'd0);

    // Back-pressure: out_ready low for 3 cycles, then stream drains in order
    idx  = 0;
    nout = 0;
    for (int c = 0; c < 7; c++) begin
      bus.out_ready = (c >= 3);
      if (c >= 3) chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      if (bus.out_valid && bus.out_ready) begin
        chk("bp_order_rd", 32'(bus.rd), 32'(nout + 1));
        nout++;
      end
      bus.in_valid = (idx < 4);
      if (idx < 4) bus.in_instr = bp_tab[idx];
      chk("bp_in_ready", 32'(bus.in_ready), 32'(exp_ir[c]));
      if (bus.in_valid && bus.in_ready) idx++;
      tick();
    end
    chk("bp_no_dup", 32'(bus.out_valid), 32'd0);
    chk("bp_out_count", 32'(nout), 32'd4);
    chk("bp_in_count", 32'(idx), 32'd4);

    // Flush with output and skid full plus a valid input
    bus.out_ready = 1'b0;
    drive(32'h00700393, 32'h0, 32'd0, 32'd0);
    tick();
    drive(32'h00800413, 32'h0, 32'd0, 32'd0);
    tick();
    chk("fl_pre_in_ready", 32'(bus.in_ready), 32'd0);
    chk("fl_pre_out_valid", 32'(bus.out_valid), 32'd1);
    drive(32'h00900493, 32'h0, 32'd0, 32'd0);
    flush = 1'b1;
    tick();
    chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_in_ready", 32'(bus.in_ready), 32'd1);
    // Flush again while in_ready is high: the offered input is dropped
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("fl2_out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl2_in_ready", 32'(bus.in_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("fl_never_appears", 32'(bus.out_valid), 32'd0);
    end

    // Async reset with output and skid occupied
    bus.out_ready = 1'b0;
    drive(32'h12345337, 32'h0, 32'd0, 32'd0);
    tick();
    drive(32'h12345297, 32'h100, 32'd0, 32'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("ar_pre_b", bus.alu_b, 32'h12345000);
    chk("ar_pre_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(bus.out_valid), 32'd0);
    chk("ar_in_ready", 32'(bus.in_ready), 32'd1);
    chk("ar_alu_b", bus.alu_b, 32'd0);
    chk("ar_alu_op", 32'(bus.alu_op), 32'(AluAdd));
    chk("ar_rd", 32'(bus.rd), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("ar_post_valid", 32'(bus.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
